// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone transmit UART.
// Register offsets, STATUS bit positions and serializer states.
package wb_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_IRQEN = 4;
  localparam int ST_LEVEL = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  function automatic logic [15:0] eff_div(
    input logic [15:0] d
  );
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/wb_uart_tx_if.sv
// Wishbone slave bundle for the transmit UART.
// Master drives the request, slave returns ack and read data.
interface wb_uart_tx_if;

  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i,
    output wb_dat_i,
    output wb_sel_i,
    output wb_cyc_i,
    output wb_stb_i,
    output wb_we_i,
    input  wb_dat_o,
    input  wb_ack_o
  );

  modport slave (
    input  wb_adr_i,
    input  wb_dat_i,
    input  wb_sel_i,
    input  wb_cyc_i,
    input  wb_stb_i,
    input  wb_we_i,
    output wb_dat_o,
    output wb_ack_o
  );

endinterface

// File: rtl/wb_uart_tx_fifo.sv
// Synchronous byte FIFO, depth 2**AW, level saturates at depth.
// A push while full is accepted only if a pop frees a slot.
module wb_uart_tx_fifo #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rdata   = mem[rp];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push)
        wp <= wp + 1'b1;
      if (do_pop)
        rp <= rp + 1'b1;
      cnt <= cnt
           + {{AW{1'b0}}, do_push}
           - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone transmit UART: TX FIFO, DIV/STATUS regs, 8N1 serializer.
// Define WB_UART_TX_IRQ_EN to enable the empty/idle interrupt.
module wb_uart_tx
  import wb_uart_pkg::*;
#(
  parameter int          FIFO_AW     = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  wb_uart_tx_if.slave wb,
  output logic        tx_o,
  output logic        irq_o
);

  tx_state_t        state;
  logic [15:0]      divisor;
  logic [15:0]      div_l;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             ovf;
  logic             req;
  logic             push;
  logic             pop;
  logic             baud_end;
  logic             full;
  logic             empty;
  logic [7:0]       rdata;
  logic [FIFO_AW:0] level;
  logic [1:0]       reg_sel;
  logic [31:0]      rd_word;
  logic             unused_bits;

`ifdef WB_UART_TX_IRQ_EN
  logic irq_en;
`endif

  assign reg_sel  = wb.wb_adr_i[3:2];
  assign req      = wb.wb_cyc_i & wb.wb_stb_i
                  & ~wb.wb_ack_o;
  assign push     = req & wb.wb_we_i
                  & (reg_sel == REG_DATA)
                  & wb.wb_sel_i[0];
  assign baud_end = (baud_cnt == div_l - 16'd1);
  assign pop      = ~empty
                  & ((state == S_IDLE)
                  | ((state == S_STOP) & baud_end));

  assign unused_bits = ^{wb.wb_adr_i[31:4],
                         wb.wb_adr_i[1:0],
                         wb.wb_dat_i[31:16],
                         wb.wb_sel_i[3:1]};

  wb_uart_tx_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .pop   (pop),
    .wdata (wb.wb_dat_i[7:0]),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    rd_word = '0;
    unique case (reg_sel)
      REG_STATUS: begin
        rd_word[ST_FULL]  = full;
        rd_word[ST_EMPTY] = empty;
        rd_word[ST_BUSY]  = (state != S_IDLE);
        rd_word[ST_OVF]   = ovf;
`ifdef WB_UART_TX_IRQ_EN
        rd_word[ST_IRQEN] = irq_en;
`endif
        rd_word[ST_LEVEL +: FIFO_AW+1] = level;
      end
      REG_DIV: rd_word[15:0] = divisor;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      divisor     <= DEFAULT_DIV;
      ovf         <= 1'b0;
`ifdef WB_UART_TX_IRQ_EN
      irq_en      <= 1'b0;
`endif
    end else begin
      wb.wb_ack_o <= req;
      wb.wb_dat_o <= (req & ~wb.wb_we_i)
                   ? rd_word : '0;
      // dropped byte: full and no pop to free a slot
      if (push & full & ~pop)
        ovf <= 1'b1;
      if (req & wb.wb_we_i) begin
        unique case (reg_sel)
          REG_STATUS: begin
            if (wb.wb_dat_i[ST_OVF])
              ovf <= 1'b0;
`ifdef WB_UART_TX_IRQ_EN
            irq_en <= wb.wb_dat_i[ST_IRQEN];
`endif
          end
          REG_DIV: divisor <= wb.wb_dat_i[15:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      tx_o     <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      div_l    <= 16'd1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            shreg    <= rdata;
            div_l    <= eff_div(divisor);
            baud_cnt <= '0;
            tx_o     <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_o     <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_o  <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_o    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            // back-to-back frame: no idle gap
            if (pop) begin
              shreg <= rdata;
              div_l <= eff_div(divisor);
              tx_o  <= 1'b0;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_UART_TX_IRQ_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      irq_o <= 1'b0;
    else
      irq_o <= irq_en & empty
             & (state == S_IDLE);
  end
`else
  assign irq_o = 1'b0;
`endif

endmodule
